// File: rtl/vector_sum_pkg.sv
// rtl/vector_sum_pkg.sv - shared types and width helper for the vector sum buffer
package vector_sum_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/block_sum_tree.sv
// rtl/block_sum_tree.sv - combinational pairwise unsigned adder tree over one input block
module block_sum_tree #(
  parameter int IN_SIZE   = 1,
  parameter int IN_WIDTH  = 8,
  parameter int SUM_WIDTH = IN_WIDTH + $clog2(IN_SIZE)
) (
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data,
  output logic [SUM_WIDTH-1:0]             sum
);

  localparam int LEVELS = $clog2(IN_SIZE);
  localparam int N      = 2 ** LEVELS;
  localparam int TW     = IN_WIDTH + LEVELS;

  // Every level is carried at the final tree width; leaves past IN_SIZE pad with zero.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [TW-1:0] node [N >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_i
        if (i < IN_SIZE) begin : g_used
          assign node[i] = TW'(data[i]);
        end else begin : g_pad
          assign node[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < (N >> l); i++) begin : g_i
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign sum = SUM_WIDTH'(g_lvl[LEVELS].node[0]);

endmodule

// File: rtl/vector_sum_buffer.sv
// rtl/vector_sum_buffer.sv - gathers one vector of elements, presents vector and total in one beat
module vector_sum_buffer
  import vector_sum_pkg::*;
#(
  parameter  int IN_WIDTH       = 8,
  parameter  int IN_PARALLELISM = 1,
  parameter  int IN_DEPTH       = 10,
  localparam int SUM_WIDTH      = sum_width(IN_WIDTH, IN_PARALLELISM),
  localparam int ACC_WIDTH      = sum_width(SUM_WIDTH, IN_DEPTH),
  localparam int TOTAL          = IN_DEPTH * IN_PARALLELISM
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in,
  input  logic                                    data_in_valid,
  output logic                                    data_in_ready,
  output logic [TOTAL-1:0][IN_WIDTH-1:0]          data_out,
  output logic [ACC_WIDTH-1:0]                    sum_out,
  output logic                                    data_out_valid,
  input  logic                                    data_out_ready
);

  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt;
  logic [ACC_WIDTH-1:0]         acc;
  logic [TOTAL-1:0][IN_WIDTH-1:0] buffer;
  logic [SUM_WIDTH-1:0]         block_sum;
  logic                         in_fire;
  logic                         last_beat;

  block_sum_tree #(
    .IN_SIZE  (IN_PARALLELISM),
    .IN_WIDTH (IN_WIDTH),
    .SUM_WIDTH(SUM_WIDTH)
  ) u_block_sum (
    .data(data_in),
    .sum (block_sum)
  );

  assign in_fire   = data_in_valid && data_in_ready;
  assign last_beat = (cnt == CNT_W'(IN_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (in_fire && last_beat) state_d = HOLD;
      HOLD:    if (data_out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    data_in_ready  = (state_q == FILL);
    data_out_valid = (state_q == HOLD);
  end

  // The first beat reloads the accumulator, so an abandoned vector never leaks into the next sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      buffer <= '0;
    end else if (in_fire) begin
      for (int k = 0; k < TOTAL; k++) begin
        if (k / IN_PARALLELISM == int'(cnt)) buffer[k] <= data_in[k % IN_PARALLELISM];
      end
      acc <= (cnt == '0) ? ACC_WIDTH'(block_sum) : acc + ACC_WIDTH'(block_sum);
      cnt <= last_beat ? '0 : cnt + CNT_W'(1);
    end
  end

  assign data_out = buffer;
  assign sum_out  = acc;

endmodule

// File: tb/tb_vector_sum_buffer.sv
// tb/tb_vector_sum_buffer.sv - scoreboard bench for vector_sum_buffer in two configurations
module tb_vector_sum_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Configuration 1: defaults (8-bit, PAR=1, DEPTH=10, ACC=12)
  logic [7:0]  d1_in;
  logic        d1_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [79:0] d1_out;
  logic [11:0] d1_sum;

  // Configuration 2: PAR=2, DEPTH=3, ACC=11
  logic [15:0] d2_in;
  logic        d2_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [47:0] d2_out;
  logic [10:0] d2_sum;

  logic [11:0] q1_sum [$];
  logic [79:0] q1_vec [$];
  logic [10:0] q2_sum [$];
  logic [47:0] q2_vec [$];

  vector_sum_buffer u_dut1 (
    .clk(clk), .rst(rst),
    .data_in(d1_in), .data_in_valid(d1_valid), .data_in_ready(d1_in_ready),
    .data_out(d1_out), .sum_out(d1_sum),
    .data_out_valid(d1_out_valid), .data_out_ready(d1_out_ready)
  );

  vector_sum_buffer #(.IN_WIDTH(8), .IN_PARALLELISM(2), .IN_DEPTH(3)) u_dut2 (
    .clk(clk), .rst(rst),
    .data_in(d2_in), .data_in_valid(d2_valid), .data_in_ready(d2_in_ready),
    .data_out(d2_out), .sum_out(d2_sum),
    .data_out_valid(d2_out_valid), .data_out_ready(d2_out_ready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && d1_out_valid && d1_out_ready) begin
      if (q1_sum.size() == 0) begin
        check("dut1_unexpected_output", 1, 0);
      end else begin
        check("dut1_sum", d1_sum, q1_sum.pop_front());
        check("dut1_data", d1_out, q1_vec.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d2_out_valid && d2_out_ready) begin
      if (q2_sum.size() == 0) begin
        check("dut2_unexpected_output", 1, 0);
      end else begin
        check("dut2_sum", d2_sum, q2_sum.pop_front());
        check("dut2_data", d2_out, q2_vec.pop_front());
      end
    end
  end

  task automatic send1(input logic [7:0] v);
    int n = 0;
    d1_in    = v;
    d1_valid = 1'b1;
    @(negedge clk);
    while (!d1_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("dut1_send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [15:0] v);
    int n = 0;
    d2_in    = v;
    d2_valid = 1'b1;
    @(negedge clk);
    while (!d2_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("dut2_send_timeout", 0, 1);
    @(posedge clk);
    #1;
    d2_valid = 1'b0;
  endtask

  // Sends ten identical beats back to back and queues the expected result.
  task automatic vector_const(input logic [7:0] v);
    logic [79:0] vec;
    for (int i = 0; i < 10; i++) vec[i*8 +: 8] = v;
    q1_sum.push_back(12'(10 * int'(v)));
    q1_vec.push_back(vec);
    for (int i = 0; i < 10; i++) send1(v);
  endtask

  initial begin
    logic [79:0] vec;
    logic [47:0] vec2;
    rst = 1'b1;
    d1_in = '0; d1_valid = 1'b0; d1_out_ready = 1'b1;
    d2_in = '0; d2_valid = 1'b0; d2_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_in_ready", d1_in_ready, 1);
    check("reset_out_valid", d1_out_valid, 0);
    check("reset_sum", d1_sum, 0);
    check("reset_data", d1_out, 0);
    check("reset2_out_valid", d2_out_valid, 0);
    check("reset2_sum", d2_sum, 0);

    // Basic ramp 1..10
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) vec[i*8 +: 8] = 8'(i + 1);
    q1_sum.push_back(12'd55);
    q1_vec.push_back(vec);
    for (int i = 0; i < 10; i++) begin
      send1(8'(i + 1));
      if (i < 9) check("fill_valid_low", d1_out_valid, 0);
    end
    d1_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", d1_out_valid, 1);
    check("hold_in_ready", d1_in_ready, 0);

    // Full-scale elements
    @(posedge clk); #1;
    vector_const(8'd255);
    d1_valid = 1'b0;

    // Backpressure in HOLD
    @(posedge clk); #1;
    d1_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) vec[i*8 +: 8] = 8'(3 * i);
    q1_sum.push_back(12'd135);
    q1_vec.push_back(vec);
    for (int i = 0; i < 10; i++) send1(8'(3 * i));
    d1_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", d1_out_valid, 1);
      check("bp_in_ready", d1_in_ready, 0);
      check("bp_sum_stable", d1_sum, 135);
      check("bp_data_stable", d1_out, vec);
    end
    @(posedge clk); #1;
    d1_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_valid", d1_out_valid, 0);
    check("release_in_ready", d1_in_ready, 1);

    // Back-to-back vectors
    @(posedge clk); #1;
    vector_const(8'd2);
    vector_const(8'd3);
    d1_valid = 1'b0;

    // Reset after a partial vector
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send1(8'd7);
    d1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", d1_out_valid, 0);
    check("midrst_sum", d1_sum, 0);
    check("midrst_data", d1_out, 0);
    @(posedge clk); #1;
    vector_const(8'd1);
    d1_valid = 1'b0;

    // PAR=2, DEPTH=3 with random gaps
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) vec2[k*8 +: 8] = 8'(k + 1);
    q2_sum.push_back(11'd21);
    q2_vec.push_back(vec2);
    for (int b = 0; b < 3; b++) begin
      send2({8'(2*b + 2), 8'(2*b + 1)});
      if (b < 2) begin
        check("par2_fill_valid_low", d2_out_valid, 0);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    check("par2_latency_valid", d2_out_valid, 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("q1_drained", 128'(q1_sum.size()), 0);
    check("q2_drained", 128'(q2_sum.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
